// File: rtl/rptr_empty.sv
// Read-side pointer, empty flag and optional fill level for the dual-clock FIFO (rclk domain).
// Optional level/almost-empty logic is built only when RPTR_RLEVEL_EN is defined.
module rptr_empty #(
  parameter int ADDRSIZE      = 4,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst_n,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                runderflow,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                raempty
);

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic              accept;

  assign accept    = rinc & ~rempty;
  assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, accept};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign raddr     = rbin[ADDRSIZE-1:0];

  // Empty compares the next pointer so the flag lands on the edge that takes the last entry.
  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rbin       <= '0;
      rptr       <= '0;
      rempty     <= 1'b1;
      runderflow <= 1'b0;
    end else begin
      rbin       <= rbinnext;
      rptr       <= rgraynext;
      rempty     <= (rgraynext == rq2_wptr);
      runderflow <= rinc & rempty;
    end
  end

`ifdef RPTR_RLEVEL_EN
  localparam logic [ADDRSIZE:0] THRESH = (ADDRSIZE+1)'(AEMPTY_THRESH);

  logic [ADDRSIZE:0] wbin_s;
  logic [ADDRSIZE:0] level_next;

  always_comb begin
    wbin_s           = '0;
    wbin_s[ADDRSIZE] = rq2_wptr[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      wbin_s[i] = wbin_s[i+1] ^ rq2_wptr[i];
    end
  end

  // Modulo subtraction handles the wrap bit; a legal writer never exceeds 2^ADDRSIZE ahead.
  assign level_next = wbin_s - rbinnext;

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      rlevel  <= '0;
      raempty <= 1'b1;
    end else begin
      rlevel  <= level_next;
      raempty <= (level_next <= THRESH);
    end
  end
`else
  assign rlevel  = '0;
  assign raempty = rempty;
`endif

endmodule
